// File: rtl/bit_sync_filt.sv
// Multi-channel bit synchroniser with per-channel glitch filter and registered edge detect.
// Each ASYNC bit is synchronised, debounced over FILT_LEN cycles and turned into rise/fall pulses.
module bit_sync_filt #(
    parameter int                   NUM_STAGES = 2,
    parameter int                   BUS_WIDTH  = 8,
    parameter int                   FILT_LEN   = 4,
    parameter logic [BUS_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] ASYNC,
    output logic [BUS_WIDTH-1:0] SYNC,
    output logic [BUS_WIDTH-1:0] RISE,
    output logic [BUS_WIDTH-1:0] FALL,
    output logic                 CHG
);

    localparam int              CNT_W    = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] sync_q, sync_d;
    logic [BUS_WIDTH-1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]                 filt_q, filt_d;
    logic [BUS_WIDTH-1:0]                 rise_q, rise_d;
    logic [BUS_WIDTH-1:0]                 fall_q, fall_d;
    logic                                 chg_q, chg_d;
    logic [BUS_WIDTH-1:0]                 s_out;
    logic [BUS_WIDTH-1:0]                 accept;

    assign s_out = sync_q[NUM_STAGES-1];

    always_comb begin
        sync_d[0] = ASYNC;
        for (int k = 1; k < NUM_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // A level must survive FILT_LEN consecutive samples; any return to the current level
    // throws away the partial count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        filt_d = filt_q;
        cnt_d  = cnt_q;
        accept = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if (s_out[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = s_out[i];
                cnt_d[i]  = '0;
                accept[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise_d = accept & s_out;
        fall_d = accept & ~s_out;
        chg_d  = |accept;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= {NUM_STAGES{RST_VAL}};
            cnt_q  <= '0;
            filt_q <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            chg_q  <= chg_d;
        end
    end

    assign SYNC = filt_q;
    assign RISE = rise_q;
    assign FALL = fall_q;
    assign CHG  = chg_q;

endmodule
